// File: rtl/mem_lsu_align.sv
// mem_lsu_align: load/store alignment stage in front of a 32-bit memory word port.
// It splits word-crossing accesses into two aligned accesses, generates byte
// strobes and lane-shifted write data, and merges/extends load data into one
// response per accepted request.
module mem_lsu_align #(
    parameter bit MISALIGN_EN = 1'b1,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [31:0]     req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_error,
    output logic            mem_r_v,
    output logic            mem_w_v,
    output logic [31:0]     mem_adr,
    output logic [XLEN-1:0] mem_data,
    output logic [3:0]      mem_strobe,
    input  logic [XLEN-1:0] mem_resp,
    input  logic            mem_resp_valid,
    input  logic            mem_resp_error
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISS0, S_WAIT0, S_ISS1, S_WAIT1, S_RESP
    } state_t;

    function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
        case (size)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            2'd2:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [3:0] nbytes_to_mask(input logic [2:0] nbytes);
        case (nbytes)
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0011;
            3'd4:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic is_split(input logic [1:0] off, input logic [2:0] nbytes);
        return ({2'b00, off} + {1'b0, nbytes}) > 4'd4;
    endfunction

    function automatic logic [XLEN-1:0] strobe_to_bits(input logic [3:0] strobe);
        return {{8{strobe[3]}}, {8{strobe[2]}}, {8{strobe[1]}}, {8{strobe[0]}}};
    endfunction

    state_t          state_q, state_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [1:0]      size_q, size_d;
    logic            unsigned_q, unsigned_d;
    logic            split_q, split_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] hi_q, hi_d;

    logic [1:0]        off;
    logic [7:0]        mask_wide;
    logic [2*XLEN-1:0] data_wide;
    logic [XLEN-1:0]   rd_shift;
    logic [XLEN-1:0]   rd_ext;

    // Lane alignment of the latched request: both halves of a split come from one shift.
    always_comb begin
        off       = addr_q[1:0];
        mask_wide = {4'b0000, nbytes_to_mask(size_to_nbytes(size_q))} << off;
        data_wide = {{XLEN{1'b0}}, wdata_q} << {off, 3'b000};
        rd_shift  = XLEN'({hi_q, lo_q} >> {off, 3'b000});
        case (size_q)
            2'd0:    rd_ext = unsigned_q ? {24'd0, rd_shift[7:0]}
                                         : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'd1:    rd_ext = unsigned_q ? {16'd0, rd_shift[15:0]}
                                         : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    // Next-state and request/data capture logic.
    always_comb begin
        // NOTE: every signal gets its hold value first, so no branch can infer a latch.
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        split_d    = split_q;
        err_d      = err_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d       = req_we;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    split_d    = is_split(req_addr[1:0], size_to_nbytes(req_size));
                    lo_d       = '0;
                    hi_d       = '0;
                    if (req_size == 2'd3 || (split_d && !MISALIGN_EN)) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISS0;
                    end
                end
            end
            S_ISS0: begin
                if (mem_resp_error) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else if (we_q) begin
                    state_d = split_q ? S_ISS1 : S_RESP;
                end else begin
                    state_d = S_WAIT0;
                end
            end
            S_WAIT0: begin
                if (mem_resp_valid) begin
                    lo_d    = mem_resp;
                    state_d = split_q ? S_ISS1 : S_RESP;
                end
            end
            S_ISS1: begin
                if (mem_resp_error) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    state_d = we_q ? S_RESP : S_WAIT1;
                end
            end
            S_WAIT1: begin
                if (mem_resp_valid) begin
                    hi_d    = mem_resp;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and latched request; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            split_q    <= 1'b0;
            err_q      <= 1'b0;
            lo_q       <= '0;
            hi_q       <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            split_q    <= split_d;
            err_q      <= err_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
        end
    end

    // Outputs decoded from registered state only; memory port is quiet outside ISS0/ISS1.
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        rsp_valid  = 1'b0;
        rsp_error  = 1'b0;
        rsp_rdata  = '0;
        mem_r_v    = 1'b0;
        mem_w_v    = 1'b0;
        mem_adr    = '0;
        mem_strobe = '0;
        mem_data   = '0;
        case (state_q)
            S_ISS0: begin
                mem_r_v    = !we_q;
                mem_w_v    = we_q;
                mem_adr    = {addr_q[31:2], 2'b00};
                mem_strobe = mask_wide[3:0];
                mem_data   = data_wide[XLEN-1:0] & strobe_to_bits(mask_wide[3:0]);
            end
            S_ISS1: begin
                mem_r_v    = !we_q;
                mem_w_v    = we_q;
                mem_adr    = {addr_q[31:2] + 30'd1, 2'b00};
                mem_strobe = mask_wide[7:4];
                mem_data   = data_wide[2*XLEN-1:XLEN] & strobe_to_bits(mask_wide[7:4]);
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_error = err_q;
                rsp_rdata = (we_q || err_q) ? '0 : rd_ext;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_lsu_align.sv
// tb_mem_lsu_align: directed bench with an access/response scoreboard and a
// small word-addressed memory responder.
module tb_mem_lsu_align;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  strobe;
        logic [31:0] data;
    } acc_t;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_valid_nm;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] mem_resp;
    logic        mem_resp_valid;
    logic        mem_resp_error;

    logic        req_ready, rsp_valid, rsp_error, mem_r_v, mem_w_v;
    logic [31:0] rsp_rdata, mem_adr, mem_data;
    logic [3:0]  mem_strobe;

    logic        nm_req_ready, nm_rsp_valid, nm_rsp_error, nm_mem_r_v, nm_mem_w_v;
    logic [31:0] nm_rsp_rdata, nm_mem_adr, nm_mem_data;
    logic [3:0]  nm_mem_strobe;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc_cnt = 0;
    int rsp_cnt = 0;
    int n0;

    acc_t exp_acc[$];
    rsp_t exp_rsp[$];
    acc_t ea;
    rsp_t er;
    logic [31:0] mem_model [logic [31:0]];
    logic        pend;
    logic [31:0] padr;

    mem_lsu_align #(.MISALIGN_EN(1'b1), .XLEN(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .mem_r_v(mem_r_v), .mem_w_v(mem_w_v), .mem_adr(mem_adr),
        .mem_data(mem_data), .mem_strobe(mem_strobe),
        .mem_resp(mem_resp), .mem_resp_valid(mem_resp_valid),
        .mem_resp_error(mem_resp_error)
    );

    mem_lsu_align #(.MISALIGN_EN(1'b0), .XLEN(32)) u_dut_nm (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_nm), .req_ready(nm_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid(nm_rsp_valid), .rsp_rdata(nm_rsp_rdata), .rsp_error(nm_rsp_error),
        .mem_r_v(nm_mem_r_v), .mem_w_v(nm_mem_w_v), .mem_adr(nm_mem_adr),
        .mem_data(nm_mem_data), .mem_strobe(nm_mem_strobe),
        .mem_resp(mem_resp), .mem_resp_valid(mem_resp_valid),
        .mem_resp_error(mem_resp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {req_ready, rsp_valid, rsp_error, rsp_rdata, mem_r_v, mem_w_v,
                  mem_adr, mem_strobe, mem_data}, {1'b1, 104'd0});
    endtask

    task automatic push_acc(input logic we, input logic [31:0] adr,
                            input logic [3:0] strobe, input logic [31:0] data);
        exp_acc.push_back('{we: we, adr: adr, strobe: strobe, data: data});
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_rsp.size() != 0 || exp_acc.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_rsp.size() + exp_acc.size(), 0);
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns, input int lat,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", req_ready, 1'b1);
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        req_valid    = 1'b1;
        exp_rsp.push_back('{cyc: cyc + lat, rdata: exp_rdata, err: exp_err});
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_done();
    endtask

    // Memory responder: read data one cycle after the read-strobe cycle.
    initial begin
        mem_resp_valid = 1'b0;
        mem_resp       = '0;
        forever begin
            @(negedge clk);
            pend = rst_n && mem_r_v && !mem_resp_error;
            padr = mem_adr;
            @(posedge clk);
            #1;
            mem_resp_valid = pend;
            mem_resp       = (pend && mem_model.exists(padr)) ? mem_model[padr] : 32'd0;
        end
    end

    // Scoreboard: compare every memory access and every response as it appears.
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
            if (mem_r_v || mem_w_v) begin
                acc_cnt++;
                chk("acc_expected", exp_acc.size() != 0, 1'b1);
                if (exp_acc.size() != 0) begin
                    ea = exp_acc.pop_front();
                    chk("acc_w_v", mem_w_v, ea.we);
                    chk("acc_r_v", mem_r_v, !ea.we);
                    chk("acc_adr", mem_adr, ea.adr);
                    chk("acc_strobe", mem_strobe, ea.strobe);
                    chk("acc_data", mem_data, ea.data);
                end
            end
            if (rsp_valid) begin
                rsp_cnt++;
                chk("rsp_expected", exp_rsp.size() != 0, 1'b1);
                if (exp_rsp.size() != 0) begin
                    er = exp_rsp.pop_front();
                    chk("rsp_cycle", cyc, er.cyc);
                    chk("rsp_rdata", rsp_rdata, er.rdata);
                    chk("rsp_error", rsp_error, er.err);
                end
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        req_valid      = 1'b0;
        req_valid_nm   = 1'b0;
        req_we         = 1'b0;
        req_addr       = '0;
        req_wdata      = '0;
        req_size       = '0;
        req_unsigned   = 1'b0;
        mem_resp_error = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("reset_idle");
        chk("reset_nm", {nm_req_ready, nm_rsp_valid, nm_mem_r_v, nm_mem_w_v}, 4'b1000);
        rst_n = 1'b1;

        // Aligned word load.
        mem_model[32'h4E20] = 32'hDEADBEEF;
        push_acc(1'b0, 32'h4E20, 4'hF, 32'h0);
        do_req(1'b0, 32'h4E20, 32'h0, 2'd2, 1'b0, 3, 32'hDEADBEEF, 1'b0);

        // Byte and halfword loads, signed and unsigned.
        mem_model[32'h4E20] = 32'h80FF1234;
        push_acc(1'b0, 32'h4E20, 4'h8, 32'h0);
        do_req(1'b0, 32'h4E23, 32'h0, 2'd0, 1'b0, 3, 32'hFFFFFF80, 1'b0);
        push_acc(1'b0, 32'h4E20, 4'h8, 32'h0);
        do_req(1'b0, 32'h4E23, 32'h0, 2'd0, 1'b1, 3, 32'h00000080, 1'b0);
        push_acc(1'b0, 32'h4E20, 4'hC, 32'h0);
        do_req(1'b0, 32'h4E22, 32'h0, 2'd1, 1'b0, 3, 32'hFFFF80FF, 1'b0);

        // Split loads.
        mem_model[32'h4E20] = 32'h11223344;
        mem_model[32'h4E24] = 32'h55667788;
        push_acc(1'b0, 32'h4E20, 4'hC, 32'h0);
        push_acc(1'b0, 32'h4E24, 4'h3, 32'h0);
        do_req(1'b0, 32'h4E22, 32'h0, 2'd2, 1'b0, 5, 32'h77881122, 1'b0);
        push_acc(1'b0, 32'h4E20, 4'h8, 32'h0);
        push_acc(1'b0, 32'h4E24, 4'h1, 32'h0);
        do_req(1'b0, 32'h4E23, 32'h0, 2'd1, 1'b1, 5, 32'h00008811, 1'b0);
        push_acc(1'b0, 32'h4E20, 4'h8, 32'h0);
        push_acc(1'b0, 32'h4E24, 4'h1, 32'h0);
        do_req(1'b0, 32'h4E23, 32'h0, 2'd1, 1'b0, 5, 32'hFFFF8811, 1'b0);

        // Aligned stores; unused upper wdata bytes must not reach the bus.
        push_acc(1'b1, 32'h4E24, 4'hF, 32'h12345678);
        do_req(1'b1, 32'h4E24, 32'h12345678, 2'd2, 1'b0, 2, 32'h0, 1'b0);
        push_acc(1'b1, 32'h4E20, 4'hC, 32'h12340000);
        do_req(1'b1, 32'h4E22, 32'hFFFF1234, 2'd1, 1'b0, 2, 32'h0, 1'b0);
        push_acc(1'b1, 32'h4E20, 4'h2, 32'h0000A500);
        do_req(1'b1, 32'h4E21, 32'h777777A5, 2'd0, 1'b0, 2, 32'h0, 1'b0);

        // Split halfword store.
        push_acc(1'b1, 32'h4E20, 4'h8, 32'hCD000000);
        push_acc(1'b1, 32'h4E24, 4'h1, 32'h000000AB);
        do_req(1'b1, 32'h4E23, 32'h0000ABCD, 2'd1, 1'b0, 3, 32'h0, 1'b0);

        // Memory error on the first half of a split load: no second access.
        mem_resp_error = 1'b1;
        push_acc(1'b0, 32'h0, 4'hC, 32'h0);
        do_req(1'b0, 32'h2, 32'h0, 2'd2, 1'b0, 2, 32'h0, 1'b1);
        mem_resp_error = 1'b0;

        // Illegal size: rejected without memory activity.
        n0 = acc_cnt;
        do_req(1'b0, 32'h4E20, 32'h0, 2'd3, 1'b0, 1, 32'h0, 1'b1);
        chk("illegal_no_access", acc_cnt, n0);

        // Split request to the instance with splitting disabled.
        @(negedge clk);
        chk("nm_ready", nm_req_ready, 1'b1);
        req_we       = 1'b0;
        req_addr     = 32'h4E22;
        req_wdata    = 32'h0;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        req_valid_nm = 1'b1;
        @(posedge clk);
        #1 req_valid_nm = 1'b0;
        @(negedge clk);
        chk("nm_rsp", {nm_rsp_valid, nm_rsp_error, nm_rsp_rdata}, {1'b1, 1'b1, 32'h0});
        chk("nm_no_mem", {nm_mem_r_v, nm_mem_w_v, nm_mem_strobe, nm_mem_adr}, 38'd0);
        @(negedge clk);
        chk("nm_back_idle", {nm_req_ready, nm_rsp_valid}, 2'b10);

        // Reset during WAIT0: the late read data must not produce a response.
        mem_model[32'h4E20] = 32'hCAFEF00D;
        push_acc(1'b0, 32'h4E20, 4'hF, 32'h0);
        @(negedge clk);
        chk("rst_pre_ready", req_ready, 1'b1);
        req_we       = 1'b0;
        req_addr     = 32'h4E20;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        req_wdata    = 32'h0;
        req_valid    = 1'b1;
        n0           = rsp_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_resp_pending", mem_resp_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_idle("rst_async_idle");
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_no_rsp", rsp_cnt, n0);
        chk("rst_acc_drained", exp_acc.size(), 0);
        push_acc(1'b0, 32'h4E20, 4'hF, 32'h0);
        do_req(1'b0, 32'h4E20, 32'h0, 2'd2, 1'b0, 3, 32'hCAFEF00D, 1'b0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
